icap_reg_reader: RTL

Reads one 32-bit configuration register of the Artix-7 configuration engine through the ICAPE2 port. Examples: BOOTSTS, to learn whether the current core came up by IPROG or by fallback; WBSTAR, to learn the SPI address of the running core. It is the read-side counterpart of the multiboot/IPROG writer. It emits the sync/read-packet/desync sequence and captures the returned word. ICAP pins are exported so a top-level arbiter can share the single ICAPE2 instance with the writer.

---
 rtl/icap_pkg.sv | 19 +
 rtl/icap_byte_bitswap.sv | 11 +
 rtl/icap_reg_reader.sv | 84 ++++++++
 3 files changed

// File: rtl/icap_pkg.sv
// icap_pkg: ICAPE2 command words, register addresses and reader FSM states.
package icap_pkg;
  localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOP        = 32'h2000_0000;
  localparam logic [31:0] ICAP_CMD_WR_HDR = 32'h3000_8001;
  localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;
  localparam logic [4:0] REG_STAT    = 5'h07;
  localparam logic [4:0] REG_IDCODE  = 5'h0C;
  localparam logic [4:0] REG_WBSTAR  = 5'h10;
  localparam logic [4:0] REG_BOOTSTS = 5'h16;
  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_TURN_R, S_RD, S_TURN_W, S_DESYNC, S_DONE
  } icap_state_e;
  // Type-1 packet, read opcode, word count 1.
  function automatic logic [31:0] type1_read_hdr(input logic [4:0] addr);
    return 32'h2800_0001 | {14'd0, addr, 13'd0};
  endfunction
endpackage

// File: rtl/icap_byte_bitswap.sv
// icap_byte_bitswap: reverses bit order inside each byte, as ICAPE2 expects.
module icap_byte_bitswap (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  for (genvar b = 0; b < 4; b++) begin : g_byte
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign dout[8*b+j] = din[8*b+7-j];
    end
  end
endmodule

// File: rtl/icap_reg_reader.sv
// icap_reg_reader: reads one configuration register via ICAPE2 (sync, type-1 read, desync).
module icap_reg_reader
  import icap_pkg::*;
#(
  parameter int RD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);
  localparam logic [3:0] RD_LAST = 4'(RD_LAT - 1);
  icap_state_e state_q, state_d;
  logic [3:0]  phase_q, phase_d, last;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] word_q, word_d, rdata_q, rdata_d, wr_word, ds_word, o_nat;
  logic        csib_q, csib_d, rdwrb_q, rdwrb_d, busy_q, busy_d, done_q, done_d;
  logic        cap_q, cap_d, wrap;
  icap_byte_bitswap u_swap_i (.din(word_q), .dout(icap_i));
  icap_byte_bitswap u_swap_o (.din(icap_o), .dout(o_nat));
  always_comb begin
    last = state_q == S_WR ? 4'd5 :
           state_q == S_RD ? RD_LAST :
           state_q == S_DESYNC ? 4'd3 :
           (state_q == S_TURN_R || state_q == S_TURN_W) ? 4'd1 : 4'd0;
    wrap = phase_q == last;
    state_d = state_q == S_IDLE ? (start ? S_WR : S_IDLE) :
              !wrap ? state_q :
              state_q == S_DONE ? S_IDLE : icap_state_e'(state_q + 3'd1);
    phase_d = (state_q == S_IDLE || wrap) ? 4'd0 : phase_q + 4'd1;
    addr_d = (state_q == S_IDLE && start) ? reg_addr : addr_q;
    // Outputs lag the state by one edge so every ICAP pin comes straight from a flop.
    wr_word = phase_q == 4'd0 ? ICAP_DUMMY :
              phase_q == 4'd1 ? ICAP_SYNC :
              phase_q == 4'd3 ? type1_read_hdr(addr_q) : ICAP_NOP;
    ds_word = phase_q == 4'd0 ? ICAP_CMD_WR_HDR :
              phase_q == 4'd1 ? ICAP_CMD_DESYNC : ICAP_NOP;
    word_d = state_q == S_WR ? wr_word : state_q == S_DESYNC ? ds_word : ICAP_DUMMY;
    csib_d = !(state_q == S_RD || state_q == S_DESYNC || (state_q == S_WR && phase_q != 4'd0));
    rdwrb_d = state_q == S_RD || (state_q == S_TURN_R && phase_q == 4'd1) ||
              (state_q == S_TURN_W && phase_q == 4'd0);
    busy_d = state_q != S_IDLE;
    done_d = state_q == S_DONE;
    cap_d = state_q == S_RD && wrap;
    rdata_d = cap_q ? o_nat : rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 4'd0;
      addr_q  <= 5'd0;
      word_q  <= ICAP_DUMMY;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cap_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
endmodule
